// File: rtl/onehot_line_pkg.sv
// Shared types and helpers for the one-hot line driver: code/line widths,
// FSM state encoding and the code-to-one-hot mapping.
package onehot_line_pkg;

    localparam int CODE_W = 3;
    localparam int LINE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } drv_state_t;

    function automatic logic [LINE_W-1:0] to_onehot(input logic [CODE_W-1:0] code);
        logic [LINE_W-1:0] line;
        line       = '0;
        line[code] = 1'b1;
        return line;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Purely combinational 3-to-8 decode sitting ahead of the driver's output register.
module decoder_3to8
    import onehot_line_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [LINE_W-1:0] line_o
);

    assign line_o = to_onehot(code_i);

endmodule

// File: rtl/onehot_line_driver.sv
// Accepts a 3-bit line code over valid/ready and holds the matching one-hot line
// for HOLD_CYCLES cycles. Define ONEHOT_LINE_DRIVER_PARITY_EN to add parity checking.
module onehot_line_driver
    import onehot_line_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
    input  logic              in_parity,
    output logic              par_err,
`endif
    input  logic              en,
    input  logic              flush,
    output logic [LINE_W-1:0] out_q,
    output logic              out_valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("onehot_line_driver: HOLD_CYCLES must be >= 1");
    end

    drv_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] out_d;
    logic [LINE_W-1:0] dec_line;
    logic              last_cycle;
    logic              accept;
    logic              load;

    decoder_3to8 u_dec (
        .code_i (in_code),
        .line_o (dec_line)
    );

    assign last_cycle = (state_q == HOLD) && (cnt_q == CNT_W'(1));
    assign in_ready   = en && !flush && ((state_q == IDLE) || last_cycle);
    assign accept     = in_valid && in_ready;

`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
    logic par_ok;
    logic par_err_d;

    // A code is only decoded if {in_parity, in_code} has even parity.
    assign par_ok    = ~^{in_parity, in_code};
    assign load      = accept && par_ok;
    assign par_err_d = accept && !par_ok;

    always_ff @(posedge clk) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= par_err_d;
    end
`else
    assign load = accept;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(HOLD_CYCLES);
                        out_d   = dec_line;
                    end
                end
                HOLD: begin
                    if (!last_cycle) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (load) begin
                        // Reload on the final hold cycle so streams have no gap.
                        cnt_d = CNT_W'(HOLD_CYCLES);
                        out_d = dec_line;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        out_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    out_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out_valid = |out_q;
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_onehot_line_driver.sv
// Scoreboard bench: one stimulus stream drives a HOLD_CYCLES=4 and a HOLD_CYCLES=1
// instance; a line/time-left model predicts each, a monitor compares every cycle.
module tb_onehot_line_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, in_valid = 1'b0, en = 1'b1, flush = 1'b0, in_parity = 1'b0;
    logic [2:0] in_code = 3'd0;

    logic       rdy4, ov4, bz4, rdy1, ov1, bz1;
    logic [7:0] oq4, oq1;
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
    logic       pe4, pe1;
`endif

    onehot_line_driver #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_code(in_code),
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
        .in_parity(in_parity), .par_err(pe4),
`endif
        .en(en), .flush(flush), .out_q(oq4), .out_valid(ov4), .busy(bz4)
    );

    onehot_line_driver #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_code(in_code),
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
        .in_parity(in_parity), .par_err(pe1),
`endif
        .en(en), .flush(flush), .out_q(oq1), .out_valid(ov1), .busy(bz1)
    );

    typedef struct {
        logic [7:0] q;
        logic       v;
        logic       b;
        logic       pe;
    } exp_t;

    exp_t eq4[$];
    exp_t eq1[$];

    // Model: which line is lit (-1 = none) and how many cycles it has left.
    int   line_m[2] = '{-1, -1};
    int   left_m[2] = '{0, 0};
    int   hold_m[2] = '{4, 1};
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Called right after inputs change at a negedge; predicts the next edge.
    task automatic tick();
        logic       par_ok, ready_m, acc;
        logic [1:0] act_rdy;
        exp_t       e;
        #1;
        act_rdy = {rdy1, rdy4};
        par_ok  = 1'b1;
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
        par_ok  = (($countones({in_parity, in_code}) % 2) == 0);
`endif
        for (int k = 0; k < 2; k++) begin
            ready_m = en && !flush && (left_m[k] <= 1);
            if (!rst) chk(k == 0 ? "in_ready_h4" : "in_ready_h1", 32'(act_rdy[k]), 32'(ready_m));
            acc  = in_valid && ready_m;
            e.pe = !rst && acc && !par_ok;
            if (rst || flush) begin
                line_m[k] = -1;
                left_m[k] = 0;
            end else if (en) begin
                if (acc && par_ok) begin
                    line_m[k] = int'(in_code);
                    left_m[k] = hold_m[k];
                end else if (left_m[k] > 0) begin
                    left_m[k]--;
                    if (left_m[k] == 0) line_m[k] = -1;
                end
            end
            e.q = (line_m[k] < 0) ? 8'h00 : 8'(1 << line_m[k]);
            e.v = (line_m[k] >= 0);
            e.b = (line_m[k] >= 0);
            if (k == 0) eq4.push_back(e);
            else        eq1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic put(input logic r, input logic v, input logic [2:0] c,
                       input logic e, input logic f, input int n);
        rst = r; in_valid = v; in_code = c; en = e; flush = f;
        in_parity = ^c;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] q,
                       input logic v, input logic b);
        chk({"out_q_", tag}, 32'(q), 32'(e.q));
        chk({"out_valid_", tag}, 32'(v), 32'(e.v));
        chk({"busy_", tag}, 32'(b), 32'(e.b));
        chk({"onehot0_", tag}, 32'($onehot0(q)), 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq4.size() > 0) begin
                e = eq4.pop_front();
                cmp("h4", e, oq4, ov4, bz4);
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
                chk("par_err_h4", 32'(pe4), 32'(e.pe));
`endif
            end
            if (eq1.size() > 0) begin
                e = eq1.pop_front();
                cmp("h1", e, oq1, ov1, bz1);
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
                chk("par_err_h1", 32'(pe1), 32'(e.pe));
`endif
            end
        end
    end

    initial begin : stim
        // Reset, then a single code 5 held for the full window.
        put(1, 0, 3'd0, 1, 0, 2);
        put(0, 1, 3'd5, 1, 0, 1);
        put(0, 0, 3'd0, 1, 0, 6);
        // Back-to-back: code 2, then 7 offered continuously until taken.
        put(0, 1, 3'd2, 1, 0, 1);
        put(0, 1, 3'd7, 1, 0, 4);
        put(0, 0, 3'd0, 1, 0, 6);
        // Sweep every code on consecutive cycles.
        for (int c = 0; c < 8; c++) put(0, 1, 3'(c), 1, 0, 1);
        put(0, 0, 3'd0, 1, 0, 6);
        // Pause mid-hold, with an offer that must be ignored.
        put(0, 1, 3'd1, 1, 0, 1);
        put(0, 0, 3'd0, 1, 0, 1);
        put(0, 1, 3'd6, 0, 0, 3);
        put(0, 0, 3'd0, 1, 0, 7);
        // Flush on the 2nd hold cycle, alongside an offer.
        put(0, 1, 3'd4, 1, 0, 1);
        put(0, 1, 3'd6, 1, 1, 1);
        put(0, 0, 3'd0, 1, 0, 3);
        // Reset mid-hold.
        put(0, 1, 3'd3, 1, 0, 1);
        put(0, 0, 3'd0, 1, 0, 1);
        put(1, 0, 3'd0, 1, 0, 1);
        put(0, 0, 3'd0, 1, 0, 2);
`ifdef ONEHOT_LINE_DRIVER_PARITY_EN
        rst = 0; in_valid = 1; in_code = 3'd3; en = 1; flush = 0; in_parity = 1'b0;
        tick();
        put(0, 0, 3'd0, 1, 0, 5);
        rst = 0; in_valid = 1; in_code = 3'd3; en = 1; flush = 0; in_parity = 1'b1;
        tick();
        put(0, 0, 3'd0, 1, 0, 5);
`endif
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            in_valid  = ($urandom_range(0, 99) < 70);
            in_code   = 3'($urandom_range(0, 7));
            en        = ($urandom_range(0, 99) < 88);
            flush     = ($urandom_range(0, 99) < 5);
            in_parity = (^in_code) ^ ($urandom_range(0, 7) == 0);
            tick();
        end
        put(0, 0, 3'd0, 1, 0, 6);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(eq4.size() + eq1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
